// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester and multiplier signal bundle for mult_arbiter
//
// Purpose: carries the N_REQ requester handshake (request, accept, response)
// and the shared shift-add multiplier bus (M/Q/START/READY/AQ).
//
// Signals:
//   req_valid   [N_REQ]        per-requester request, held until accepted
//   req_a/req_b [N_REQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready   [N_REQ]        one-hot accept pulse
//   rsp_valid   [N_REQ]        one-hot, one-cycle result pulse
//   rsp_product [2*WIDTH]      result, meaningful only with rsp_valid
//   rsp_error                  1 = operation aborted by the watchdog
//   M, Q        [WIDTH]        operands presented to the multiplier
//   START                      multiplier start strobe
//   READY                      multiplier idle/done (high) or busy (low)
//   AQ          [2*WIDTH]      multiplier product
//
// Modports: slave = the arbiter, master = requesters plus multiplier.

interface mult_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]     rsp_product;
  logic                   rsp_error;
  logic [WIDTH-1:0]       M;
  logic [WIDTH-1:0]       Q;
  logic                   START;
  logic                   READY;
  logic [2*WIDTH-1:0]     AQ;

  modport slave (
    input  req_valid, req_a, req_b, READY, AQ,
    output req_ready, rsp_valid, rsp_product, rsp_error, M, Q, START
  );

  modport master (
    output req_valid, req_a, req_b, READY, AQ,
    input  req_ready, rsp_valid, rsp_product, rsp_error, M, Q, START
  );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one shift-add multiplier
//
// Purpose: grants one of N_REQ requesters at a time, latches its operands onto
// M/Q, pulses START, waits for READY to drop (busy) and rise again (done), and
// returns AQ to the winner. A watchdog turns a hung operation into an error
// response with a zero product.
//
// Ports:
//   clock   system clock, all state changes on the rising edge
//   reset   synchronous, active-high
//   bus     mult_arbiter_if.slave (requester handshake + multiplier bus)

module mult_arbiter #(
  parameter int N_REQ          = 2,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clock,
  input  logic          reset,
  mult_arbiter_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_ptr;
  logic [TW-1:0]      r_timer;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_q;
  logic [2*WIDTH-1:0] r_product;
  logic               r_error;

  logic [PW-1:0]      w_grant;
  logic [PW-1:0]      w_cand;
  logic               w_grant_vld;
  logic               w_accept;
  logic               w_timeout;
  logic [TW-1:0]      w_timer_inc;

  // Round-robin search: start just after the last winner so it ends up with
  // the lowest priority this round.
  always_comb begin
    w_grant     = r_ptr;
    w_cand      = r_ptr;
    w_grant_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % N_REQ);
      if (!w_grant_vld && bus.req_valid[w_cand]) begin
        w_grant     = w_cand;
        w_grant_vld = 1'b1;
      end
    end
  end

  // A grant is only issued while the multiplier reports idle, so a multiplier
  // still busy from its own reset never sees a START it cannot honour.
  assign w_accept    = (r_state == S_IDLE) && w_grant_vld && bus.READY;
  assign w_timeout   = (r_timer >= TW'(TIMEOUT_CYCLES));
  assign w_timer_inc = w_timeout ? r_timer : r_timer + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.START     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          bus.req_ready[w_grant] = 1'b1;
          w_state_nxt            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.START   = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // READY still high here is stale from the previous operation, not a
        // completion; only its falling edge moves us on.
        if (!bus.READY) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_timeout) begin
          w_state_nxt = S_RESPOND;
        end
      end
      S_WAIT_DONE: begin
        if (bus.READY || w_timeout) begin
          w_state_nxt = S_RESPOND;
        end
      end
      S_RESPOND: begin
        bus.rsp_valid[r_ptr] = 1'b1;
        w_state_nxt          = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr     <= PW'(N_REQ - 1);
      r_timer   <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_product <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr <= w_grant;
        r_m   <= bus.req_a[int'(w_grant)*WIDTH +: WIDTH];
        r_q   <= bus.req_b[int'(w_grant)*WIDTH +: WIDTH];
      end
      case (r_state)
        S_ISSUE: begin
          // Counts from the START cycle, so the watchdog bounds START to done.
          r_timer <= TW'(1);
        end
        S_WAIT_BUSY: begin
          if (bus.READY) begin
            if (w_timeout) begin
              r_product <= '0;
              r_error   <= 1'b1;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
        end
        S_WAIT_DONE: begin
          if (bus.READY) begin
            r_product <= bus.AQ;
            r_error   <= 1'b0;
          end else if (w_timeout) begin
            r_product <= '0;
            r_error   <= 1'b1;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.M           = r_m;
  assign bus.Q           = r_q;
  assign bus.rsp_product = r_product;
  assign bus.rsp_error   = r_error;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter

module tb_mult_arbiter;

  localparam int N = 2;
  localparam int W = 8;
  localparam int T = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  mult_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // multiplier model controls
  int mm_lat       = 1;
  bit mm_stuck     = 1'b0;
  bit mm_hold_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [N-1:0] mask, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1);
    bus.req_valid = mask;
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_product"}, 32'(bus.rsp_product), 0);
    chk({tag, "_rsp_error"}, 32'(bus.rsp_error), 0);
    chk({tag, "_M"}, 32'(bus.M), 0);
    chk({tag, "_Q"}, 32'(bus.Q), 0);
    chk({tag, "_START"}, 32'(bus.START), 0);
  endtask

  task automatic wait_accept(output int g);
    g = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (|(bus.req_ready & bus.req_valid)) begin
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) g = i;
        break;
      end
    end
    if (g < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: no req_ready within 100 cycles at %0t", $time);
    end
  endtask

  task automatic wait_rsp(output logic [N-1:0] v, output logic [15:0] p, output logic e, output int cnt);
    v   = '0;
    p   = '0;
    e   = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      cnt++;
      if (|bus.rsp_valid) begin
        v = bus.rsp_valid;
        p = bus.rsp_product;
        e = bus.rsp_error;
        break;
      end
    end
    if (v == '0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid within 200 cycles at %0t", $time);
    end
  endtask

  // Multiplier model: START seen -> READY low for mm_lat cycles -> READY high with AQ.
  initial begin : mult_model
    int busy;
    logic [7:0]  pm;
    logic [7:0]  pq;
    logic [15:0] pend;
    bit st;
    busy = 0;
    pend = '0;
    bus.READY = 1'b1;
    bus.AQ    = '0;
    forever begin
      @(negedge clock);
      st = bus.START;
      pm = bus.M;
      pq = bus.Q;
      @(posedge clock);
      #1;
      if (st && !mm_stuck) begin
        busy   = mm_lat;
        pend   = 16'(pm) * 16'(pq);
        bus.AQ = 16'hDEAD;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) bus.AQ = pend;
      end
      bus.READY = (busy == 0) && !mm_hold_busy;
    end
  end

  // Reference model: transaction-level round-robin with latency from the rules.
  typedef struct {
    int          idx;
    logic [15:0] prod;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  initial begin : monitor
    exp_t        pend_q[$];
    exp_t        e;
    int          cyc;
    int          last_g;
    int          g;
    bit          inflight;
    bit          exp_start;
    logic [7:0]  exp_m;
    logic [7:0]  exp_mq;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp;
    cyc = 0;
    last_g = N - 1;
    inflight = 1'b0;
    exp_start = 1'b0;
    exp_m = '0;
    exp_mq = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        pend_q.delete();
        last_g    = N - 1;
        inflight  = 1'b0;
        exp_start = 1'b0;
      end else begin
        chk("mon_START", 32'(bus.START), 32'(exp_start));
        if (exp_start) begin
          chk("mon_M", 32'(bus.M), 32'(exp_m));
          chk("mon_Q", 32'(bus.Q), 32'(exp_mq));
        end
        exp_start = 1'b0;
        g = rr_pick(bus.req_valid, last_g);
        exp_ready = '0;
        if (!inflight && bus.READY && g >= 0) exp_ready[g] = 1'b1;
        chk("mon_req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (exp_ready != '0) begin
          e.idx  = g;
          e.err  = mm_stuck;
          exp_m  = bus.req_a[g*W +: W];
          exp_mq = bus.req_b[g*W +: W];
          e.prod = mm_stuck ? 16'h0 : 16'(exp_m) * 16'(exp_mq);
          e.acc  = cyc;
          e.lat  = mm_stuck ? T + 2 : 3 + mm_lat;
          pend_q.push_back(e);
          last_g    = g;
          inflight  = 1'b1;
          exp_start = 1'b1;
        end
        exp_rsp = '0;
        if (pend_q.size() > 0 && cyc - pend_q[0].acc == pend_q[0].lat) begin
          exp_rsp[pend_q[0].idx] = 1'b1;
          chk("mon_rsp_product", 32'(bus.rsp_product), 32'(pend_q[0].prod));
          chk("mon_rsp_error", 32'(bus.rsp_error), 32'(pend_q[0].err));
        end
        chk("mon_rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        if (exp_rsp != '0) begin
          void'(pend_q.pop_front());
          inflight = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [N-1:0] mask;
    logic [7:0]   a0;
    logic [7:0]   b0;
    logic [7:0]   a1;
    logic [7:0]   b1;
    int           lat;
    int           exp_g;
    logic [15:0]  exp_p;
  } vec_t;

  initial begin : main
    vec_t        tbl[6];
    int          g;
    int          cnt;
    logic [N-1:0] v;
    logic [15:0] p;
    logic        e;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [7:0]  ga;
    logic [7:0]  gb;

    tbl[0] = '{2'b01, 8'h0C, 8'h0A, 8'h00, 8'h00, 8, 0, 16'h0078};
    tbl[1] = '{2'b11, 8'hFF, 8'hFF, 8'h02, 8'h03, 1, 1, 16'h0006};
    tbl[2] = '{2'b11, 8'hFF, 8'hFF, 8'h02, 8'h03, 3, 0, 16'hFE01};
    tbl[3] = '{2'b01, 8'h10, 8'h10, 8'h00, 8'h00, 2, 0, 16'h0100};
    tbl[4] = '{2'b10, 8'h00, 8'h00, 8'h00, 8'h55, 1, 1, 16'h0000};
    tbl[5] = '{2'b10, 8'h00, 8'h00, 8'h0F, 8'h0F, 5, 1, 16'h00E1};

    set_req('0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("por");

    for (int i = 0; i < 6; i++) begin
      tick();
      mm_lat = tbl[i].lat;
      set_req(tbl[i].mask, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1);
      wait_accept(g);
      chk("tbl_grant", 32'(g), 32'(tbl[i].exp_g));
      tick();
      bus.req_valid = '0;
      @(negedge clock);
      chk("tbl_M", 32'(bus.M), 32'(tbl[i].exp_g == 0 ? tbl[i].a0 : tbl[i].a1));
      chk("tbl_Q", 32'(bus.Q), 32'(tbl[i].exp_g == 0 ? tbl[i].b0 : tbl[i].b1));
      chk("tbl_START", 32'(bus.START), 1);
      wait_rsp(v, p, e, cnt);
      chk("tbl_rsp_valid", 32'(v), 32'(1 << tbl[i].exp_g));
      chk("tbl_rsp_product", 32'(p), 32'(tbl[i].exp_p));
      chk("tbl_rsp_error", 32'(e), 0);
      chk("tbl_latency", 32'(cnt + 1), 32'(3 + tbl[i].lat));
    end

    // contention: both held, grants alternate 0,1,0,1
    tick();
    mm_lat = 2;
    set_req(2'b11, 8'hFF, 8'hFF, 8'h02, 8'h03);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(v, p, e, cnt);
      chk("cont_rsp_valid", 32'(v), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_rsp_product", 32'(p), (k % 2 == 0) ? 32'hFE01 : 32'h0006);
    end
    tick();
    bus.req_valid = '0;

    // busy at idle: READY held low after reset, no grant until it rises
    tick();
    mm_hold_busy = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(2'b10, 8'h00, 8'h00, 8'h09, 8'h07);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("busy_req_ready", 32'(bus.req_ready), 0);
      chk("busy_START", 32'(bus.START), 0);
    end
    tick();
    mm_hold_busy = 1'b0;
    mm_lat = 1;
    wait_accept(g);
    chk("busy_grant", 32'(g), 1);
    tick();
    bus.req_valid = '0;
    wait_rsp(v, p, e, cnt);
    chk("busy_rsp_valid", 32'(v), 2);
    chk("busy_rsp_product", 32'(p), 32'h003F);

    // timeout: multiplier ignores START, READY stays high
    tick();
    mm_stuck = 1'b1;
    set_req(2'b01, 8'h03, 8'h05, 8'h00, 8'h00);
    wait_accept(g);
    chk("to_grant", 32'(g), 0);
    tick();
    bus.req_valid = '0;
    wait_rsp(v, p, e, cnt);
    chk("to_rsp_valid", 32'(v), 1);
    chk("to_rsp_error", 32'(e), 1);
    chk("to_rsp_product", 32'(p), 0);
    chk("to_latency_bound", 32'(cnt <= T + 2), 1);
    tick();
    mm_stuck = 1'b0;
    set_req(2'b10, 8'h00, 8'h00, 8'h07, 8'h06);
    wait_accept(g);
    chk("to_next_grant", 32'(g), 1);
    tick();
    bus.req_valid = '0;
    wait_rsp(v, p, e, cnt);
    chk("to_next_product", 32'(p), 32'h002A);
    chk("to_next_error", 32'(e), 0);

    // reset during WAIT_DONE
    tick();
    mm_lat = 10;
    set_req(2'b01, 8'h11, 8'h11, 8'h00, 8'h00);
    wait_accept(g);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("midrst");
    tick();
    mm_lat = 2;
    set_req(2'b11, 8'h01, 8'h02, 8'h03, 8'h04);
    wait_accept(g);
    chk("midrst_first_grant", 32'(g), 0);
    tick();
    bus.req_valid = '0;
    wait_rsp(v, p, e, cnt);
    chk("midrst_rsp_valid", 32'(v), 1);
    chk("midrst_rsp_product", 32'(p), 32'h0002);

    // randomized traffic; monitor model checks every cycle
    for (int it = 0; it < 40; it++) begin
      tick();
      mm_lat   = $urandom_range(1, 6);
      mm_stuck = ($urandom_range(0, 5) == 0);
      ra = 8'($urandom);
      rb = 8'($urandom);
      set_req(2'($urandom_range(1, 3)), ra, rb, 8'($urandom), 8'($urandom));
      wait_accept(g);
      if (g < 0) break;
      ga = bus.req_a[g*W +: W];
      gb = bus.req_b[g*W +: W];
      tick();
      bus.req_valid[g] = 1'b0;
      wait_rsp(v, p, e, cnt);
      chk("rnd_rsp_valid", 32'(v), 32'(1 << g));
      chk("rnd_rsp_error", 32'(e), 32'(mm_stuck));
      chk("rnd_rsp_product", 32'(p), mm_stuck ? 32'h0 : 32'(16'(ga) * 16'(gb)));
    end
    tick();
    bus.req_valid = '0;
    mm_stuck = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
